// File: rtl/blake_round_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// blake_pkg
// Shared definitions for the BLAKE-512 round sequencer: controller state
// encoding, round geometry constants and the message-permutation selector.
// Ports: none (package).
// ----------------------------------------------------------------------------
package blake_pkg;

    localparam int STEPS_PER_ROUND = 8;
    localparam int SIGMA_PERIOD    = 10;
    localparam int IDX_W           = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_FINAL,
        ST_DONE
    } state_t;

    // The ten sigma permutations repeat, so rounds 10..15 reuse 0..5.
    // A single conditional subtract is enough because round < 16 < 2*10.
    function automatic logic [3:0] sigma_of(input logic [3:0] round);
        return (round >= 4'(SIGMA_PERIOD)) ? round - 4'(SIGMA_PERIOD) : round;
    endfunction

endpackage

// File: rtl/blake_round_ctrl_if.sv
// ----------------------------------------------------------------------------
// blake_round_ctrl_if
// Bundle between the hash top-level / datapath and the round sequencer.
//   start        : request to compress one block (host -> controller)
//   ready        : controller idle, start is accepted
//   init_load    : pulse, load v[0..15]
//   g_valid      : one G step issued this cycle
//   counter_idx  : {round, step} of the issued step (state mux select)
//   sigma_round  : message permutation select for the issued step
//   wb_en/wb_idx : G result write-back strobe and the step it belongs to
//   final_en     : pulse, compute h'
//   done         : pulse, block complete
// Modports: master = host/datapath side, slave = controller side.
// ----------------------------------------------------------------------------
interface blake_round_ctrl_if;
    import blake_pkg::*;

    logic             start;
    logic             ready;
    logic             init_load;
    logic             g_valid;
    logic [IDX_W-1:0] counter_idx;
    logic [3:0]       sigma_round;
    logic             wb_en;
    logic [IDX_W-1:0] wb_idx;
    logic             final_en;
    logic             done;

    modport master (
        output start,
        input  ready, init_load, g_valid, counter_idx, sigma_round,
        input  wb_en, wb_idx, final_en, done
    );

    modport slave (
        input  start,
        output ready, init_load, g_valid, counter_idx, sigma_round,
        output wb_en, wb_idx, final_en, done
    );

endinterface

// File: rtl/blake_round_ctrl_inflight_pipe.sv
// ----------------------------------------------------------------------------
// blake_inflight_pipe
// G_LAT-deep shift register of {valid, idx} tracking G steps in flight.
//   clk      : clock
//   flush    : synchronous clear of every stage
//   in_valid : a G step is issued this cycle
//   in_idx   : index of that step
//   wb_en    : output stage valid (result ready for write-back)
//   wb_idx   : index held in the output stage
//   empty    : no step will remain in flight after the next clock edge
// ----------------------------------------------------------------------------
module blake_inflight_pipe
    import blake_pkg::*;
#(
    parameter int G_LAT = 2
) (
    input  logic             clk,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             wb_en,
    output logic [IDX_W-1:0] wb_idx,
    output logic             empty
);

    logic [G_LAT-1:0] vld;
    logic [IDX_W-1:0] idx [G_LAT];

    // Idle stages carry a zero index so wb_idx is 0 whenever wb_en is low.
    always_ff @(posedge clk) begin
        if (flush) begin
            vld <= '0;
            for (int i = 0; i < G_LAT; i++) idx[i] <= '0;
        end else begin
            vld[0] <= in_valid;
            idx[0] <= in_valid ? in_idx : '0;
            for (int i = 1; i < G_LAT; i++) begin
                vld[i] <= vld[i-1];
                idx[i] <= idx[i-1];
            end
        end
    end

    assign wb_en  = vld[G_LAT-1];
    assign wb_idx = idx[G_LAT-1];

    // The output stage retires this cycle, so it does not count. The step
    // entering now does, which lets the controller issue in the cycle
    // right after a write-back.
    always_comb begin
        empty = !in_valid;
        for (int i = 0; i < G_LAT - 1; i++) begin
            if (vld[i]) empty = 1'b0;
        end
    end

endmodule

// File: rtl/blake_round_ctrl.sv
// ----------------------------------------------------------------------------
// blake_round_ctrl
// Round sequencer for the single-G-core BLAKE-512 compression datapath:
// init pulse, 8*ROUNDS G-step issues with write-back strobes, final pulse,
// done pulse.
//   clk : clock (rising edge)
//   rst : synchronous active-high reset
//   bus : blake_round_ctrl_if.slave (start/ready handshake, datapath strobes)
// Parameters: ROUNDS (1..16), G_LAT (>=1).
// Build option: BLAKE_HALFROUND_OVERLAP_EN lets the four steps of a
// half-round issue back to back instead of waiting for each write-back.
// ----------------------------------------------------------------------------
module blake_round_ctrl
    import blake_pkg::*;
#(
    parameter int ROUNDS = 16,
    parameter int G_LAT  = 2
) (
    input  logic             clk,
    input  logic             rst,
    blake_round_ctrl_if.slave bus
);

    localparam int               TOTAL_STEPS = STEPS_PER_ROUND * ROUNDS;
    localparam logic [IDX_W:0]   TOTAL       = TOTAL_STEPS[IDX_W:0];
    localparam logic [IDX_W-1:0] LAST_IDX    = TOTAL_STEPS[IDX_W-1:0] - 1'b1;

    state_t           state, state_next;
    logic [IDX_W:0]   issue_cnt;
    logic             issue;
    logic             pipe_empty;
    logic             wb_en_i;
    logic [IDX_W-1:0] wb_idx_i;

    logic             init_load_q;
    logic             g_valid_q;
    logic [IDX_W-1:0] counter_idx_q;
    logic [3:0]       sigma_q;
    logic             final_q;
    logic             done_q;

    // Next state and the issue decision. Step 0 is issued straight out of
    // INIT; afterwards each step waits for the tracker to drain, except that
    // the overlap build only makes half-round openers wait.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            ST_IDLE:  if (bus.start) state_next = ST_INIT;
            ST_INIT: begin
                state_next = ST_RUN;
                issue      = 1'b1;
            end
            ST_RUN: begin
                if (issue_cnt < TOTAL) begin
`ifdef BLAKE_HALFROUND_OVERLAP_EN
                    issue = pipe_empty || (issue_cnt[1:0] != 2'd0);
`else
                    issue = pipe_empty;
`endif
                end
                if (wb_en_i && (wb_idx_i == LAST_IDX)) state_next = ST_FINAL;
            end
            ST_FINAL: state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State register and registered outputs. Pulses are decoded from the
    // next state so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            issue_cnt     <= '0;
            init_load_q   <= 1'b0;
            g_valid_q     <= 1'b0;
            counter_idx_q <= '0;
            sigma_q       <= '0;
            final_q       <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state       <= state_next;
            init_load_q <= (state_next == ST_INIT);
            final_q     <= (state_next == ST_FINAL);
            done_q      <= (state_next == ST_DONE);
            g_valid_q   <= issue;
            sigma_q     <= issue ? sigma_of(issue_cnt[IDX_W-1:3]) : 4'd0;

            if (state_next != ST_RUN)
                counter_idx_q <= '0;
            else if (issue)
                counter_idx_q <= issue_cnt[IDX_W-1:0];

            if (state == ST_IDLE)
                issue_cnt <= '0;
            else if (issue)
                issue_cnt <= issue_cnt + 1'b1;
        end
    end

    blake_inflight_pipe #(
        .G_LAT (G_LAT)
    ) u_pipe (
        .clk      (clk),
        .flush    (rst),
        .in_valid (g_valid_q),
        .in_idx   (counter_idx_q),
        .wb_en    (wb_en_i),
        .wb_idx   (wb_idx_i),
        .empty    (pipe_empty)
    );

    assign bus.ready       = (state == ST_IDLE);
    assign bus.init_load   = init_load_q;
    assign bus.g_valid     = g_valid_q;
    assign bus.counter_idx = counter_idx_q;
    assign bus.sigma_round = sigma_q;
    assign bus.wb_en       = wb_en_i;
    assign bus.wb_idx      = wb_idx_i;
    assign bus.final_en    = final_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_blake_round_ctrl.sv
// ----------------------------------------------------------------------------
// tb_blake_round_ctrl
// Directed bench for blake_round_ctrl with ROUNDS=16, G_LAT=2. Expected
// issue / write-back cycles follow the closed-form schedule of the selected
// build (BLAKE_HALFROUND_OVERLAP_EN or default).
// ----------------------------------------------------------------------------
module tb_blake_round_ctrl;
    import blake_pkg::*;

`ifdef BLAKE_HALFROUND_OVERLAP_EN
    localparam int LAST_ISSUE = 191;
`else
    localparam int LAST_ISSUE = 383;
`endif

    logic clk = 1'b0;
    logic rst;
    int   nAssert = 0;
    int   nFail   = 0;

    blake_round_ctrl_if bus ();

    blake_round_ctrl #(
        .ROUNDS (16),
        .G_LAT  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Safety net in case the DUT or a loop wedges the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no end of test, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    // Cycle t (counted from the accepted start) issues a G step? Returns the
    // step index through k.
    function automatic bit expIssue(input int t, output int k);
        int u;
        k = 0;
        if (t < 2) return 1'b0;
        u = t - 2;
`ifdef BLAKE_HALFROUND_OVERLAP_EN
        if ((u % 6) < 4 && (u / 6) < 32) begin
            k = 4 * (u / 6) + (u % 6);
            return 1'b1;
        end
`else
        if ((u % 3) == 0 && (u / 3) < 128) begin
            k = u / 3;
            return 1'b1;
        end
`endif
        return 1'b0;
    endfunction

    task automatic applyStimulus(input logic s, input logic r);
        bus.start = s;
        rst       = r;
    endtask

    task automatic checkOutput(input string tag, input int cyc,
                               input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s @cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic checkIdle(input int cyc);
        checkOutput("idle_ready",       cyc, 32'(bus.ready),       32'd1);
        checkOutput("idle_init_load",   cyc, 32'(bus.init_load),   32'd0);
        checkOutput("idle_g_valid",     cyc, 32'(bus.g_valid),     32'd0);
        checkOutput("idle_counter_idx", cyc, 32'(bus.counter_idx), 32'd0);
        checkOutput("idle_sigma_round", cyc, 32'(bus.sigma_round), 32'd0);
        checkOutput("idle_wb_en",       cyc, 32'(bus.wb_en),       32'd0);
        checkOutput("idle_wb_idx",      cyc, 32'(bus.wb_idx),      32'd0);
        checkOutput("idle_final_en",    cyc, 32'(bus.final_en),    32'd0);
        checkOutput("idle_done",        cyc, 32'(bus.done),        32'd0);
    endtask

    // One block from an accepted start. A busy start is pulsed at cycle 50.
    // With rstAt > 0, rst is asserted in that cycle and the following cycles
    // must look like a freshly reset controller.
    task automatic runBlock(input int rstAt);
        int  k;
        int  wk;
        int  lastK;
        int  wbCount;
        int  doneCount;
        bit  iss;
        bit  wbe;

        lastK     = 0;
        wbCount   = 0;
        doneCount = 0;
        checkOutput("ready_before_start", 0, 32'(bus.ready), 32'd1);
        applyStimulus(1'b1, 1'b0);

        for (int t = 1; t <= LAST_ISSUE + 5; t++) begin
            @(negedge clk);
            applyStimulus(t == 50, t == rstAt);
            iss = expIssue(t, k);
            if (iss) lastK = k;
            if (t >= LAST_ISSUE + 3) lastK = 0;
            wbe = expIssue(t - 2, wk);

            checkOutput("ready",       t, 32'(bus.ready),       32'(t >= LAST_ISSUE + 5));
            checkOutput("init_load",   t, 32'(bus.init_load),   32'(t == 1));
            checkOutput("g_valid",     t, 32'(bus.g_valid),     32'(iss));
            checkOutput("counter_idx", t, 32'(bus.counter_idx), 32'(lastK));
            checkOutput("sigma_round", t, 32'(bus.sigma_round), iss ? 32'((k / 8) % 10) : 32'd0);
            checkOutput("wb_en",       t, 32'(bus.wb_en),       32'(wbe));
            if (wbe) begin
                checkOutput("wb_idx",   t, 32'(bus.wb_idx), 32'(wk));
                checkOutput("wb_order", t, 32'(wbCount),    32'(wk));
            end
            checkOutput("final_en",    t, 32'(bus.final_en),    32'(t == LAST_ISSUE + 3));
            checkOutput("done",        t, 32'(bus.done),        32'(t == LAST_ISSUE + 4));
            wbCount   += int'(bus.wb_en);
            doneCount += int'(bus.done);
            if (t == rstAt) break;
        end

        if (rstAt == 0) begin
            checkOutput("wb_count",   LAST_ISSUE + 5, 32'(wbCount),   32'd128);
            checkOutput("done_count", LAST_ISSUE + 5, 32'(doneCount), 32'd1);
        end else begin
            for (int j = 1; j <= 8; j++) begin
                @(negedge clk);
                applyStimulus(1'b0, 1'b0);
                checkIdle(rstAt + j);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        applyStimulus(1'b0, 1'b1);
        repeat (2) @(negedge clk);
        $display("[TB] reset state");
        checkIdle(-1);
        applyStimulus(1'b0, 1'b0);
        @(negedge clk);
        checkIdle(-1);

        $display("[TB] start together with rst");
        applyStimulus(1'b1, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        checkIdle(1);
        @(negedge clk);
        checkIdle(2);

        $display("[TB] full block with busy start at cycle 50");
        runBlock(0);

        $display("[TB] rst at cycle 100");
        runBlock(100);

        $display("[TB] rst at cycle 3 with step 0 in flight");
        runBlock(3);

        $display("[TB] fresh block after reset");
        runBlock(0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule

// File: doc/blake_round_ctrl.md
# blake_round_ctrl

Round sequencer for the single-G-core BLAKE-512 compression datapath. It accepts a start request and pulses the state-vector initialisation. It then issues all 128 G-function steps (16 rounds × 8 steps) by driving the 7-bit `counter_idx` into the state mux, and tracks in-flight G results to generate write-back strobes. Finally it pulses finalisation and signals completion. It sits between the hash top-level and the state register / state mux / G-core datapath.

## Interface
- `ROUNDS`, 16: rounds per block; legal range 1..16, because `counter_idx` is 7 bits.
- `G_LAT`, 2: cycles from `g_valid` to G result valid; legal values are ≥1.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request to compress one block; sampled only while `ready`=1.
- `ready` out 1: controller is idle and accepts `start`.
- `init_load` out 1: one-cycle pulse that loads v[0..15] from h, salt, constants and counter.
- `g_valid` out 1: issues one G step this cycle.
- `counter_idx` out 7: index of the issued step, {round[3:0], step[2:0]}; drives the state mux.
- `sigma_round` out 4: round mod 10; selects the message permutation for the issued step.
- `wb_en` out 1: G result is valid and must be written into v this cycle.
- `wb_idx` out 7: `counter_idx` of the step being written back.
- `final_en` out 1: one-cycle pulse that computes h' = h ^ s ^ v_lo ^ v_hi.
- `done` out 1: one-cycle pulse; the block is complete.

## Operation
- FSM states: IDLE → INIT → RUN → FINAL → DONE → IDLE.
- IDLE:
  - `ready`=1.
  - `start`=1 moves the FSM to INIT.
  - `start` in any other state is ignored and not queued.
- INIT: `init_load`=1 for one cycle, then RUN with the issue counter at 0.
- RUN: issue counter k runs 0..8·ROUNDS−1, and `counter_idx` = k.
  - Steps 0–3 (columns) are mutually independent, and steps 4–7 (diagonals) are mutually independent.
  - Step 4 depends on all of steps 0–3; step 0 of round r+1 depends on all of steps 4–7 of round r.
- In-flight tracker: a G_LAT-deep shift register of {valid, idx}.
  - Stage 0 loads {`g_valid`, `counter_idx`}.
  - The output stage drives `wb_en`/`wb_idx`.
  - `wb_en` is never asserted unless a matching `g_valid` occurred exactly G_LAT cycles earlier.
- Issue rule (default build): issue step k only when the tracker is empty, i.e. strictly issue → wait → write back.
- RUN → FINAL: the cycle after write-back of step 8·ROUNDS−1.
- FINAL: `final_en`=1 for one cycle, then DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `sigma_round` = `counter_idx`[6:3] mod 10 (rounds 10–15 map to 0–5). It is valid whenever `g_valid`=1 and is 0 otherwise.
- `counter_idx` holds its last issued value between issues and is 0 outside RUN.

## Timing
- Reset values: `ready`=1 (state IDLE); `init_load`, `g_valid`, `wb_en`, `final_en` and `done` all 0; `counter_idx`, `wb_idx` and `sigma_round` all 0; tracker cleared.
- `rst` mid-operation: on the next cycle the FSM is in IDLE, the tracker is flushed, and no `wb_en` is produced for G steps still in flight.
- `rst` and `start` in the same cycle: `rst` wins and the controller stays in IDLE.
- Cycle numbering: `start` is accepted at cycle 0, `init_load` is at cycle 1, and the first `g_valid` is at cycle 2.
- Default build: step k issues at 2+(G_LAT+1)·k and writes back at 2+(G_LAT+1)·k+G_LAT.
- `final_en` comes one cycle after the last write-back and `done` one cycle after that. `ready` is 1 again the cycle after `done`.
- All outputs are registered except `ready`, which decodes the state.

## Configuration
- Macro: `BLAKE_HALFROUND_OVERLAP_EN`.
- Defined: within a half-round (steps 0–3, or steps 4–7), steps issue on consecutive cycles regardless of tracker occupancy.
  - The first step of the next half-round waits until the tracker is empty.
  - Half-round period is 4+G_LAT cycles, and the datapath must accept a result every cycle.
- Undefined: the strict issue/wait rule above applies, giving G_LAT+1 cycles per step.

## Structure
- `blake_pkg` holds:
  - the FSM state enum;
  - the `STEPS_PER_ROUND`=8 and `SIGMA_PERIOD`=10 constants;
  - the `IDX_W`=7 constant.
- Sub-module `blake_inflight_pipe`, parameterised by G_LAT, holds the valid+idx shift register with synchronous flush. It provides `wb_en`/`wb_idx` and an `empty` flag.

## Test plan
All scenarios use ROUNDS=16 and G_LAT=2.
- Single `start` pulse after reset → `ready`=0 at cycle 1; `init_load` at cycle 1; `g_valid` with `counter_idx`=0 at cycle 2; `wb_en` with `wb_idx`=0 at cycle 4; `g_valid` with `counter_idx`=1 at cycle 5.
- Full block, default build → the last issue (idx 127) is at cycle 383, its `wb_en` at 385, `final_en` at 386 and `done` at 387; exactly 128 `wb_en` pulses with `wb_idx` 0..127 in order.
- Full block with `BLAKE_HALFROUND_OVERLAP_EN` → issues at cycles 2,3,4,5 then 8,9,10,11; the last issue (idx 127) is at 191, `final_en` at 194 and `done` at 195.
- `sigma_round` check → equals 9 at `counter_idx`=72, 0 at 80 and 5 at 120.
- `rst` asserted at cycle 100 with a G step in flight → from cycle 101 all outputs hold their reset values, no `wb_en` appears, and a fresh `start` restarts at `counter_idx`=0.
- `start` pulsed at cycle 50 (busy), and `start` together with `rst` → both are ignored; exactly one `done` per accepted start.
